frame_capture_ctrl: RTL and testbench
=====================================

Name: frame_capture_ctrl

Overview:
- Hardware frame-capture sequencer for the racing-game video path.
- Watches the game's hsync/vsync/rgb outputs, arms on a start command and captures a programmed number of whole frames.
- Converts each captured frame into a token stream (pixel codes, line ends, frame marks) buffered in an internal FIFO.
- A host or UART dumper drains the FIFO through a valid/ready port.

Parameters:
- SAMPLE_DIV, 2, clocks per pixel sample (2 or more).
- FIFO_DEPTH, 16, token FIFO entries (power of 2).
- FCNT_W, 8, width of the frame counter and frame request.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- hsync  in  1  game hsync, same clock domain, low = sync pulse
- vsync  in  1  game vsync, same clock domain, low = sync pulse
- rgb  in  3  game pixel colour
- start  in  1  one-cycle pulse; begins a capture, accepted only in IDLE or DONE
- abort  in  1  one-cycle pulse; returns to IDLE and flushes the FIFO
- frames_req  in  FCNT_W  number of frames to capture, sampled on start; 0 is treated as 1
- out_valid  out  1  token available
- out_ready  in  1  consumer accepts the token
- out_data  out  5  token: [4:3] kind (00 pixel, 01 line end, 10 frame mark), [2:0] rgb for pixel tokens, else 0
- busy  out  1  high in ARM or CAPTURE
- done  out  1  high in DONE
- overflow  out  1  sticky; a token was dropped because the FIFO was full
- frame_cnt  out  FCNT_W  frames started in the current capture

Behaviour:
- Reset: state IDLE, FIFO empty, out_valid=0, out_data=0, busy=0, done=0, overflow=0, frame_cnt=0. Sync edge registers load 1.
- Edge detection: hs_q/vs_q are registered every clock.
  - hsync fall = hs_q & ~hsync.
  - vsync rise = ~vs_q & vsync.
- Sample divider:
  - Counts 0 to SAMPLE_DIV-1 and wraps.
  - Forced to 0 on hsync fall.
  - A sample tick occurs when the count is 0.
- State IDLE: start moves to ARM; latches frames_req (0 becomes 1); clears overflow and frame_cnt.
- State ARM: waits for a vsync rise, then moves to CAPTURE, pushes a frame mark and sets frame_cnt=1. No other tokens are generated.
- State CAPTURE:
  - Token priority, at most one token per cycle: frame mark > line end > pixel.
  - Pixel token: sample tick with hsync=1 and vsync=1; payload is rgb.
  - Samples taken during vertical blanking (hsync=1, vsync=0) produce no token.
  - Line-end token: hsync fall. If it coincides with a vsync rise, the line end is suppressed.
  - On a vsync rise with frame_cnt < latched request: frame_cnt increments and a frame mark is pushed.
  - On a vsync rise with frame_cnt == latched request: move to DONE, push nothing, frame_cnt holds.
- State DONE: done=1. The FIFO keeps draining. start re-arms exactly as from IDLE, and the FIFO is not flushed.
- abort (any state): next state IDLE, FIFO pointers cleared, out_valid=0, frame_cnt=0. overflow holds.
  - abort has priority over start in the same cycle.
- FIFO:
  - Synchronous and first-word-fall-through. out_data/out_valid come from a registered head, so latency is 1 clock from push to out_valid.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle while full: both succeed and the count is unchanged.
  - Push while full with no pop: token dropped, overflow set.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data must stay stable while out_valid=1 and out_ready=0.
- Reset mid-capture: identical to power-up reset, effective next edge.

Test Plan:
- Synthetic 8-pixel by 3-line frames (hsync low 2 clk, vsync low 1 line), SAMPLE_DIV=2, frames_req=2, out_ready=1 -> stream is {frame mark, 4 pixels, line end} x lines for 2 frames, then done=1 at the 3rd vsync rise; frame_cnt=2; overflow=0.
- frames_req=0 -> behaves as 1: exactly one frame mark, done at the 2nd vsync rise.
- out_ready=0 throughout, FIFO_DEPTH=16 -> exactly 16 tokens are held and overflow goes high on the 17th push.
  - Then raise out_ready: the 16 tokens come out in order, first is frame mark 5'b10000.
- hsync fall and vsync rise in the same cycle -> only the frame mark (5'b10000) is pushed; no line end.
- abort mid-CAPTURE with 5 tokens queued -> next cycle IDLE, out_valid=0, busy=0, frame_cnt=0.
  - A following start captures normally.
- Backpressure toggling out_ready every cycle with rgb=3'b101 pixels -> out_data stable while stalled; every pixel token is 5'b00101; no token lost or duplicated.

Source files
------------

// File: rtl/frame_capture_ctrl_if.sv
// Token stream port of the frame-capture sequencer: valid/ready with a 5-bit token.
// Token layout: [4:3] kind (00 pixel, 01 line end, 10 frame mark), [2:0] rgb or 0.
interface frame_capture_ctrl_if;
   logic       valid;
   logic       ready;
   logic [4:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/frame_capture_ctrl.sv
// Frame-capture sequencer: turns hsync/vsync/rgb into a token stream for a
// programmed number of frames, buffered in a first-word-fall-through FIFO.
//
// state     | meaning
// S_IDLE    | waiting for start, FIFO may be empty or draining
// S_ARM     | armed, waiting for the vsync rise that opens the first frame
// S_CAPTURE | emitting frame marks, line ends and pixel tokens
// S_DONE    | requested frames captured, FIFO keeps draining, start re-arms
module frame_capture_ctrl #(
   parameter int SAMPLE_DIV = 2,
   parameter int FIFO_DEPTH = 16,
   parameter int FCNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 hsync_i,
   input  logic                 vsync_i,
   input  logic [2:0]           rgb_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [FCNT_W-1:0]    frames_req_i,
   frame_capture_ctrl_if.master out_if,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 overflow_o,
   output logic [FCNT_W-1:0]    frame_cnt_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int DIV_W = $clog2(SAMPLE_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic [1:0]       K_PIX     = 2'b00;
   localparam logic [1:0]       K_LE      = 2'b01;
   localparam logic [1:0]       K_MARK    = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;

   state_t state_q, state_d;

   logic              hs_q, vs_q;
   logic              hs_fall, vs_rise;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              sample_tick;

   logic [FCNT_W-1:0] req_q, req_d;
   logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic              overflow_q, overflow_d;
   logic              ovf_clr;

   logic              push_req;
   logic [4:0]        push_data;
   logic              start_ok;

   logic [4:0]        mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  remain;
   logic              out_valid_q, out_valid_d;
   logic [4:0]        out_data_q, out_data_d;
   logic              do_push, do_pop, full, drop;

   assign hs_fall     = hs_q & ~hsync_i;
   assign vs_rise     = ~vs_q & vsync_i;
   assign sample_tick = (div_q == '0);
   assign start_ok    = start_i & ((state_q == S_IDLE) | (state_q == S_DONE));

   always_ff @(posedge clk) begin
      if (reset) begin
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
         div_q <= '0;
      end else begin
         hs_q  <= hsync_i;
         vs_q  <= vsync_i;
         div_q <= div_d;
      end
   end

   // Phase restarts on each hsync fall so every line samples on the same pixels.
   always_comb begin
      div_d = div_q + DIV_W'(1);
      if (hs_fall || div_q == DIV_LAST) div_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (abort_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: if (start_ok) state_d = S_ARM;
            S_ARM:          if (vs_rise) state_d = S_CAPTURE;
            S_CAPTURE:      if (vs_rise && frame_cnt_q >= req_q) state_d = S_DONE;
            default:        state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      push_req    = 1'b0;
      push_data   = '0;
      frame_cnt_d = frame_cnt_q;
      req_d       = req_q;
      ovf_clr     = 1'b0;
      busy_o      = (state_q == S_ARM) || (state_q == S_CAPTURE);
      done_o      = (state_q == S_DONE);
      if (abort_i) begin
         frame_cnt_d = '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_ok) begin
                  req_d       = (frames_req_i == '0) ? FCNT_W'(1) : frames_req_i;
                  frame_cnt_d = '0;
                  ovf_clr     = 1'b1;
               end
            end
            S_ARM: begin
               if (vs_rise) begin
                  push_req    = 1'b1;
                  push_data   = {K_MARK, 3'b000};
                  frame_cnt_d = FCNT_W'(1);
               end
            end
            S_CAPTURE: begin
               // A vsync rise owns the cycle: it either opens a frame or ends the capture.
               if (vs_rise) begin
                  if (frame_cnt_q < req_q) begin
                     push_req    = 1'b1;
                     push_data   = {K_MARK, 3'b000};
                     frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                  end
               end else if (hs_fall) begin
                  push_req  = 1'b1;
                  push_data = {K_LE, 3'b000};
               end else if (sample_tick && hsync_i && vsync_i) begin
                  push_req  = 1'b1;
                  push_data = {K_PIX, rgb_i};
               end
            end
            default: ;
         endcase
      end
   end

   assign do_pop  = out_valid_q & out_if.ready;
   assign full    = (count_q == CNT_FULL);
   assign do_push = push_req & (~full | do_pop);
   assign drop    = push_req & full & ~do_pop;

   // The head register always mirrors the oldest entry; an entry pushed into an
   // otherwise empty FIFO goes straight to the head for one-clock latency.
   always_comb begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(do_pop);
      wr_ptr_d    = wr_ptr_q + PTR_W'(do_push);
      count_d     = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      remain      = count_q - CNT_W'(do_pop);
      out_valid_d = (count_d != '0);
      out_data_d  = '0;
      if (count_d != '0) begin
         if (remain == '0) out_data_d = push_data;
         else              out_data_d = mem_q[rd_ptr_d];
      end
      if (abort_i) begin
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         count_d     = '0;
         out_valid_d = 1'b0;
         out_data_d  = '0;
      end
      overflow_d = ovf_clr ? 1'b0 : (overflow_q | drop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         overflow_q  <= 1'b0;
         frame_cnt_q <= '0;
         req_q       <= FCNT_W'(1);
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         overflow_q  <= overflow_d;
         frame_cnt_q <= frame_cnt_d;
         req_q       <= req_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign out_if.valid = out_valid_q;
   assign out_if.data  = out_data_q;
   assign overflow_o   = overflow_q;
   assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl: synthetic 8x3 frames, scoreboard of
// expected tokens, checks on control outputs and handshake stability.
module tb_frame_capture_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       hsync, vsync;
   logic [2:0] rgb;
   logic       start, abort;
   logic [7:0] frames_req;
   logic       busy, done, overflow;
   logic [7:0] frame_cnt;

   frame_capture_ctrl_if tok ();

   frame_capture_ctrl #(.SAMPLE_DIV(2), .FIFO_DEPTH(16), .FCNT_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .hsync_i      (hsync),
      .vsync_i      (vsync),
      .rgb_i        (rgb),
      .start_i      (start),
      .abort_i      (abort),
      .frames_req_i (frames_req),
      .out_if       (tok),
      .busy_o       (busy),
      .done_o       (done),
      .overflow_o   (overflow),
      .frame_cnt_o  (frame_cnt)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [4:0] exp_q [$];
   logic       prev_stall = 1'b0;
   logic [4:0] prev_data  = '0;
   bit         stop_toggle;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard and stall-stability monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 32'(tok.valid), 32'd1);
            check("stall_data", 32'(tok.data), 32'(prev_data));
         end
         if (tok.valid && tok.ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL unexpected_token: observed 0x%0h expected none", tok.data);
            end else begin
               check("token", 32'(tok.data), 32'(exp_q.pop_front()));
            end
         end
         prev_stall = tok.valid && !tok.ready && !abort;
         prev_data  = tok.data;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One 10-clock line: hsync low for 2 clocks, then 8 active pixels.
   task automatic video_line(bit blank, logic [2:0] c);
      for (int i = 0; i < 10; i++) begin
         hsync = (i >= 2);
         vsync = !blank;
         rgb   = (i >= 2) ? c : 3'b000;
         tick();
      end
   endtask

   task automatic exp_frame(logic [2:0] c0, logic [2:0] step);
      logic [2:0] c;
      c = c0;
      exp_q.push_back(5'b10000);
      for (int l = 0; l < 3; l++) begin
         repeat (4) exp_q.push_back({2'b00, c});
         exp_q.push_back(5'b01000);
         c = c + step;
      end
   endtask

   task automatic drive_frame(logic [2:0] c0, logic [2:0] step);
      logic [2:0] c;
      c = c0;
      for (int l = 0; l < 3; l++) begin
         video_line(1'b0, c);
         c = c + step;
      end
      video_line(1'b1, 3'b000);
   endtask

   // Blank line, n captured frames, then the vsync rise that should end capture.
   task automatic capture_frames(int n, logic [2:0] c0, logic [2:0] step);
      video_line(1'b1, 3'b000);
      for (int f = 0; f < n; f++) begin
         exp_frame(c0, step);
         drive_frame(c0, step);
      end
      video_line(1'b0, c0);
   endtask

   task automatic pulse_start(logic [7:0] n);
      frames_req = n;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic wait_drain(string tag);
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
      tick();
      check(tag, 32'(exp_q.size()), 32'd0);
      check({tag, "_valid"}, 32'(tok.valid), 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      hsync      = 1'b1;
      vsync      = 1'b1;
      rgb        = 3'b000;
      start      = 1'b0;
      abort      = 1'b0;
      frames_req = 8'd0;
      tok.ready  = 1'b1;
      repeat (3) tick();
      check("rst_valid", 32'(tok.valid), 32'd0);
      check("rst_data", 32'(tok.data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      reset = 1'b0;
      repeat (3) tick();

      // Two frames, consumer always ready.
      pulse_start(8'd2);
      check("t1_busy_armed", 32'(busy), 32'd1);
      capture_frames(2, 3'd1, 3'd1);
      check("t1_done", 32'(done), 32'd1);
      check("t1_busy", 32'(busy), 32'd0);
      check("t1_frame_cnt", 32'(frame_cnt), 32'd2);
      check("t1_overflow", 32'(overflow), 32'd0);
      wait_drain("t1_drain");

      // Request of zero behaves as one frame; restart straight from DONE.
      pulse_start(8'd0);
      check("t2_frame_cnt_clr", 32'(frame_cnt), 32'd0);
      check("t2_done_clr", 32'(done), 32'd0);
      capture_frames(1, 3'd4, 3'd2);
      check("t2_done", 32'(done), 32'd1);
      check("t2_frame_cnt", 32'(frame_cnt), 32'd1);
      wait_drain("t2_drain");

      // Consumer stalled: the first frame fills exactly 16 entries, the next mark drops.
      tok.ready = 1'b0;
      pulse_start(8'd2);
      video_line(1'b1, 3'b000);
      exp_frame(3'd5, 3'd1);
      drive_frame(3'd5, 3'd1);
      check("t3_full_no_ovf", 32'(overflow), 32'd0);
      check("t3_head_mark", 32'(tok.data), 32'h10);
      video_line(1'b0, 3'd5);
      check("t3_ovf_17th", 32'(overflow), 32'd1);
      video_line(1'b0, 3'd6);
      video_line(1'b0, 3'd7);
      video_line(1'b1, 3'b000);
      video_line(1'b0, 3'd5);
      check("t3_done", 32'(done), 32'd1);
      check("t3_ovf_sticky", 32'(overflow), 32'd1);
      tok.ready = 1'b1;
      wait_drain("t3_drain");

      // Abort with five tokens queued, then a clean capture.
      tok.ready = 1'b0;
      pulse_start(8'd1);
      check("t5_ovf_clr", 32'(overflow), 32'd0);
      video_line(1'b1, 3'b000);
      video_line(1'b0, 3'd2);
      check("t5_frame_cnt_pre", 32'(frame_cnt), 32'd1);
      check("t5_valid_pre", 32'(tok.valid), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_valid", 32'(tok.valid), 32'd0);
      check("t5_frame_cnt", 32'(frame_cnt), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      repeat (3) tick();
      check("t5_valid_hold", 32'(tok.valid), 32'd0);
      tok.ready = 1'b1;
      pulse_start(8'd1);
      capture_frames(1, 3'd6, 3'd1);
      check("t5_done_after", 32'(done), 32'd1);
      check("t5_frame_cnt_after", 32'(frame_cnt), 32'd1);
      wait_drain("t5_drain");

      // Ready toggling every cycle with constant colour 101.
      pulse_start(8'd1);
      stop_toggle = 1'b0;
      fork
         begin
            capture_frames(1, 3'b101, 3'd0);
            stop_toggle = 1'b1;
         end
         begin
            while (!stop_toggle) begin
               tok.ready = ~tok.ready;
               tick();
            end
         end
      join
      tok.ready = 1'b1;
      wait_drain("t6_drain");
      check("t6_overflow", 32'(overflow), 32'd0);
      check("t6_done", 32'(done), 32'd1);

      // Reset in the middle of a capture.
      tok.ready = 1'b0;
      pulse_start(8'd2);
      video_line(1'b1, 3'b000);
      video_line(1'b0, 3'd3);
      reset = 1'b1;
      tick();
      check("t7_valid", 32'(tok.valid), 32'd0);
      check("t7_data", 32'(tok.data), 32'd0);
      check("t7_busy", 32'(busy), 32'd0);
      check("t7_frame_cnt", 32'(frame_cnt), 32'd0);
      exp_q.delete();
      reset     = 1'b0;
      tok.ready = 1'b1;
      repeat (5) tick();
      check("t7_idle_valid", 32'(tok.valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
